// File: rtl/vga_scan_driver.sv
// Raster scan generator: h/v counters, palette lookup and VGA sync generation.
// All video outputs are registered one cycle after the counters they describe.
module vga_scan_driver #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [2:0]  color_in,
  output logic [15:0] pixel_x,
  output logic [15:0] pixel_y,
  output logic [7:0]  rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        vblank,
  output logic        frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_MAX      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_MAX      = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  logic [7:0] rgb_nxt;
  logic       hsync_nxt;
  logic       vsync_nxt;
  logic       vblank_nxt;
  logic       tick_nxt;
  logic       active;

  function automatic logic [7:0] pal(input logic [2:0] idx);
    case (idx)
      3'd0:    pal = 8'h00;
      3'd1:    pal = 8'hE0;
      3'd2:    pal = 8'h03;
      3'd3:    pal = 8'h1C;
      3'd4:    pal = 8'hFC;
      3'd5:    pal = 8'hB6;
      3'd6:    pal = 8'hE3;
      default: pal = 8'hFF;
    endcase
  endfunction

  // Disabling the scan parks both counters at the origin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!enable) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_MAX) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_MAX) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  always_comb begin
    active     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    rgb_nxt    = active ? pal(color_in) : 8'h00;
    hsync_nxt  = ((h_cnt >= H_SYNC_BEG) && (h_cnt <= H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_nxt  = ((v_cnt >= V_SYNC_BEG) && (v_cnt <= V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    vblank_nxt = (v_cnt >= V_ACT);
    tick_nxt   = (h_cnt == '0) && (v_cnt == V_ACT);
  end

  // Output stage shares one cycle of delay so sync, blanking and colour stay aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb        <= 8'h00;
      hsync      <= ~SYNC_POL;
      vsync      <= ~SYNC_POL;
      vblank     <= 1'b0;
      frame_tick <= 1'b0;
    end else if (!enable) begin
      rgb        <= 8'h00;
      hsync      <= ~SYNC_POL;
      vsync      <= ~SYNC_POL;
      vblank     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      rgb        <= rgb_nxt;
      hsync      <= hsync_nxt;
      vsync      <= vsync_nxt;
      vblank     <= vblank_nxt;
      frame_tick <= tick_nxt;
    end
  end

  assign pixel_x = {{(16-HW){1'b0}}, h_cnt};
  assign pixel_y = {{(16-VW){1'b0}}, v_cnt};

endmodule

// File: tb/tb_vga_scan_driver.sv
// Bench for vga_scan_driver using a shrunken 16x11 raster so full frames stay short.
// Table vectors cover palette/latency/hsync/enable; hand sequences cover frames and resets.
module tb_vga_scan_driver;

  localparam int H_ACTIVE = 8;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 3;
  localparam int V_ACTIVE = 6;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam int H_TOTAL  = 16;
  localparam int V_TOTAL  = 11;
  localparam int FRAME    = H_TOTAL * V_TOTAL;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [2:0]  color_in;
  logic [15:0] pixel_x;
  logic [15:0] pixel_y;
  logic [7:0]  rgb;
  logic        hsync;
  logic        vsync;
  logic        vblank;
  logic        frame_tick;

  int errors = 0;
  int checks = 0;
  int mh = 0;
  int mv = 0;

  typedef struct {
    logic       en;
    logic [2:0] col;
    int         px;
    int         py;
    logic [7:0] rgb;
    logic       hs;
    logic       vs;
    logic       vb;
    logic       tk;
  } vec_t;

  vec_t vecs[20];
  logic [7:0] pal_ref[8];

  vga_scan_driver #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .color_in(color_in),
    .pixel_x(pixel_x),
    .pixel_y(pixel_y),
    .rgb(rgb),
    .hsync(hsync),
    .vsync(vsync),
    .vblank(vblank),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic en, input logic [2:0] col, input int px, input int py,
                              input logic [7:0] r, input logic hs, input logic vs,
                              input logic vb, input logic tk);
    vec_t v;
    v.en = en; v.col = col; v.px = px; v.py = py; v.rgb = r;
    v.hs = hs; v.vs = vs; v.vb = vb; v.tk = tk;
    return v;
  endfunction

  task automatic applyStimulus(input logic en, input logic [2:0] col);
    enable   = en;
    color_in = col;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Advances the reference counters by one enabled clock.
  task automatic advance_model();
    if (mh == H_TOTAL - 1) begin
      mh = 0;
      mv = (mv == V_TOTAL - 1) ? 0 : mv + 1;
    end else begin
      mh = mh + 1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mh = 0;
    mv = 0;
  endtask

  initial begin
    int ph, pv, bad, tick_bad, ff_cnt, hs_low, vs_low, vb_cnt, held_bad;
    int ticks[$];
    logic prev_vb;
    logic [7:0]  e_rgb;
    logic        e_hs, e_vs, e_vb, e_tk;

    pal_ref = '{8'h00, 8'hE0, 8'h03, 8'h1C, 8'hFC, 8'hB6, 8'hE3, 8'hFF};

    vecs[0]  = mk(1, 3'd1, 1,  0, 8'hE0, 1, 1, 0, 0);
    vecs[1]  = mk(1, 3'd2, 2,  0, 8'h03, 1, 1, 0, 0);
    vecs[2]  = mk(1, 3'd3, 3,  0, 8'h1C, 1, 1, 0, 0);
    vecs[3]  = mk(1, 3'd4, 4,  0, 8'hFC, 1, 1, 0, 0);
    vecs[4]  = mk(1, 3'd5, 5,  0, 8'hB6, 1, 1, 0, 0);
    vecs[5]  = mk(1, 3'd6, 6,  0, 8'hE3, 1, 1, 0, 0);
    vecs[6]  = mk(1, 3'd7, 7,  0, 8'hFF, 1, 1, 0, 0);
    vecs[7]  = mk(1, 3'd0, 8,  0, 8'h00, 1, 1, 0, 0);
    vecs[8]  = mk(1, 3'd7, 9,  0, 8'h00, 1, 1, 0, 0);
    vecs[9]  = mk(1, 3'd7, 10, 0, 8'h00, 1, 1, 0, 0);
    vecs[10] = mk(1, 3'd7, 11, 0, 8'h00, 0, 1, 0, 0);
    vecs[11] = mk(1, 3'd7, 12, 0, 8'h00, 0, 1, 0, 0);
    vecs[12] = mk(1, 3'd7, 13, 0, 8'h00, 0, 1, 0, 0);
    vecs[13] = mk(1, 3'd7, 14, 0, 8'h00, 1, 1, 0, 0);
    vecs[14] = mk(1, 3'd7, 15, 0, 8'h00, 1, 1, 0, 0);
    vecs[15] = mk(1, 3'd7, 0,  1, 8'h00, 1, 1, 0, 0);
    vecs[16] = mk(1, 3'd5, 1,  1, 8'hB6, 1, 1, 0, 0);
    vecs[17] = mk(0, 3'd7, 0,  0, 8'h00, 1, 1, 0, 0);
    vecs[18] = mk(0, 3'd7, 0,  0, 8'h00, 1, 1, 0, 0);
    vecs[19] = mk(1, 3'd2, 1,  0, 8'h03, 1, 1, 0, 0);

    rst      = 1'b0;
    enable   = 1'b1;
    color_in = 3'($urandom_range(7));
    repeat (3) begin
      @(negedge clk);
      color_in = 3'($urandom_range(7));
    end
    checkOutput("reset_px", pixel_x, 0);
    checkOutput("reset_py", pixel_y, 0);
    checkOutput("reset_rgb", rgb, 8'h00);
    checkOutput("reset_hsync", hsync, 1);
    checkOutput("reset_vsync", vsync, 1);
    checkOutput("reset_vblank", vblank, 0);
    checkOutput("reset_tick", frame_tick, 0);
    rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].en, vecs[i].col);
      checkOutput($sformatf("v%0d_px", i), pixel_x, vecs[i].px);
      checkOutput($sformatf("v%0d_py", i), pixel_y, vecs[i].py);
      checkOutput($sformatf("v%0d_rgb", i), rgb, vecs[i].rgb);
      checkOutput($sformatf("v%0d_hsync", i), hsync, vecs[i].hs);
      checkOutput($sformatf("v%0d_vsync", i), vsync, vecs[i].vs);
      checkOutput($sformatf("v%0d_vblank", i), vblank, vecs[i].vb);
      checkOutput($sformatf("v%0d_tick", i), frame_tick, vecs[i].tk);
    end

    // Two full frames with colour forced to 7, compared against the raster model.
    do_reset();
    bad = 0; tick_bad = 0; ff_cnt = 0; hs_low = 0; vs_low = 0; vb_cnt = 0;
    prev_vb = 1'b0;
    for (int c = 0; c < 2 * FRAME + 20; c++) begin
      ph = mh;
      pv = mv;
      applyStimulus(1'b1, 3'd7);
      advance_model();
      e_rgb = (ph < H_ACTIVE && pv < V_ACTIVE) ? 8'hFF : 8'h00;
      e_hs  = !(ph >= H_ACTIVE + H_FP && ph <= H_ACTIVE + H_FP + H_SYNC - 1);
      e_vs  = !(pv >= V_ACTIVE + V_FP && pv <= V_ACTIVE + V_FP + V_SYNC - 1);
      e_vb  = (pv >= V_ACTIVE);
      e_tk  = (ph == 0 && pv == V_ACTIVE);
      if (pixel_x != 16'(mh) || pixel_y != 16'(mv) || rgb != e_rgb || hsync != e_hs ||
          vsync != e_vs || vblank != e_vb || frame_tick != e_tk)
        bad++;
      if (frame_tick) begin
        ticks.push_back(c);
        if (!(vblank && !prev_vb)) tick_bad++;
      end
      if (ticks.size() == 1) begin
        if (rgb == 8'hFF) ff_cnt++;
        if (!hsync) hs_low++;
        if (!vsync) vs_low++;
        if (vblank) vb_cnt++;
      end
      prev_vb = vblank;
    end
    checkOutput("frame_model_mismatches", bad, 0);
    checkOutput("frame_tick_count", ticks.size(), 2);
    if (ticks.size() >= 2)
      checkOutput("frame_tick_spacing", ticks[1] - ticks[0], FRAME);
    checkOutput("tick_vblank_align", tick_bad, 0);
    checkOutput("active_ff_pixels", ff_cnt, H_ACTIVE * V_ACTIVE);
    checkOutput("hsync_low_clocks", hs_low, H_SYNC * V_TOTAL);
    checkOutput("vsync_low_clocks", vs_low, V_SYNC * H_TOTAL);
    checkOutput("vblank_clocks", vb_cnt, (V_TOTAL - V_ACTIVE) * H_TOTAL);

    // Asynchronous reset in the middle of an active line.
    for (int i = 0; i < 2 * FRAME && !(mh == 5 && mv == 3); i++) begin
      applyStimulus(1'b1, 3'd7);
      advance_model();
    end
    checkOutput("prereset_px", pixel_x, 5);
    checkOutput("prereset_rgb", rgb, 8'hFF);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_reset_px", pixel_x, 0);
    checkOutput("async_reset_py", pixel_y, 0);
    checkOutput("async_reset_rgb", rgb, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    mh = 0;
    mv = 0;
    applyStimulus(1'b1, 3'd7);
    advance_model();
    checkOutput("post_reset_px", pixel_x, 1);
    checkOutput("post_reset_py", pixel_y, 0);
    checkOutput("post_reset_rgb", rgb, 8'hFF);

    // Enable dropped for ten cycles mid-frame, then scanning restarts at origin.
    for (int i = 0; i < 2 * FRAME && !(mh == 3 && mv == 2); i++) begin
      applyStimulus(1'b1, 3'd7);
      advance_model();
    end
    checkOutput("predisable_py", pixel_y, 2);
    held_bad = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 3'd7);
      if (pixel_x != 16'd0 || pixel_y != 16'd0 || rgb != 8'h00 || hsync != 1'b1 ||
          vsync != 1'b1 || vblank != 1'b0 || frame_tick != 1'b0)
        held_bad++;
    end
    checkOutput("disabled_hold_mismatches", held_bad, 0);
    applyStimulus(1'b1, 3'd4);
    checkOutput("resume_px", pixel_x, 1);
    checkOutput("resume_py", pixel_y, 0);
    checkOutput("resume_rgb", rgb, pal_ref[4]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
